// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - load/store bridge from core memory port to req/ack word bus
//
// Purpose: turns each core load/store into one req/ack bus transaction with
// byte enables, stalls the core until it completes, and pulses Fault on a
// misaligned access, a bus error or an ack timeout.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   MemRead, MemWrite     core access request (both set = write)
//   Funct3                access size in [1:0]: 00 byte, 01 half, 1x word
//   ALUResult, WriteData  byte address and right-justified store data
//   ReadData              loaded word shifted so the addressed byte is at [7:0]
//   Stall, Fault          core hold request, one-cycle fault pulse
//   bus_req/we/addr/be/wdata  bus request side, held stable during REQ
//   bus_rdata/ack/err     bus response side
module dmem_bridge #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        Fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   input  logic        bus_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        fault_q, fault_d;
   logic [1:0]  off_q, off_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   logic        acc;
   logic        misaligned;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;

   // Sign/zero extension happens downstream, so the unsigned bit is not needed.
   logic        unused_funct3;
   assign unused_funct3 = Funct3[2];

   assign acc = MemRead | MemWrite;

   // Decode size into lane enables, replicated store data and alignment check.
   always_comb begin
      misaligned = 1'b0;
      be_new     = 4'b1111;
      wdata_new  = WriteData;
      case (Funct3[1:0])
         2'b00: begin
            be_new    = 4'b0001 << ALUResult[1:0];
            wdata_new = {4{WriteData[7:0]}};
         end
         2'b01: begin
            be_new     = 4'b0011 << ALUResult[1:0];
            wdata_new  = {2{WriteData[15:0]}};
            misaligned = ALUResult[0];
         end
         default: begin
            misaligned = |ALUResult[1:0];
         end
      endcase
      if (!MemWrite) begin
         wdata_new = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fault_d = fault_q;
      off_d   = off_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (acc) begin
               if (misaligned) begin
                  fault_d = 1'b1;
                  state_d = DONE;
               end else begin
                  fault_d = 1'b0;
                  cnt_d   = '0;
                  off_d   = ALUResult[1:0];
                  we_d    = MemWrite;
                  addr_d  = {ALUResult[31:2], 2'b00};
                  be_d    = be_new;
                  wdata_d = wdata_new;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            // An error wins over a simultaneous ack; an ack on the last
            // allowed cycle still completes normally.
            if (bus_err) begin
               fault_d = 1'b1;
               state_d = DONE;
            end else if (bus_ack) begin
               if (!we_q) begin
                  rdata_d = bus_rdata >> {off_q, 3'b000};
               end
               state_d = DONE;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
               fault_d = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fault_q <= 1'b0;
         off_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
         off_q   <= off_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign Stall     = acc & (state_q != DONE);
   assign Fault     = (state_q == DONE) & fault_q;
   assign bus_req   = (state_q == REQ);
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_be    = be_q;
   assign bus_wdata = wdata_q;
   // A faulted access shows zero for its completion cycle without disturbing
   // the last good load value.
   assign ReadData  = Fault ? 32'd0 : rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - testbench for dmem_bridge
module tb_dmem_bridge;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] ALUResult, WriteData, ReadData;
   logic        Stall, Fault;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;
   logic        bus_ack, bus_err;

   dmem_bridge #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
      .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData),
      .Stall(Stall), .Fault(Fault),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] rd_model = 32'd0;

   // mode: 0 ack, 1 err+ack, 2 err alone, 3 no response
   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          mode;
      int          delay;
      logic [31:0] rdata;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic        exp_we;
      logic [31:0] exp_wdata;
      logic [31:0] exp_load;
      logic        exp_fault;
      int          exp_nreq;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic run_access(input vec_t v);
      int n_stall;
      int n_req;
      bit done;
      logic [31:0] exp_rd;
      MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3;
      ALUResult = v.addr; WriteData = v.wdata; bus_rdata = v.rdata;
      bus_ack = 1'b0; bus_err = 1'b0;
      n_stall = 0; n_req = 0; done = 1'b0;
      #1;
      for (int c = 0; c < 40 && !done; c++) begin
         if (Stall) begin
            n_stall++;
            chk("fault_while_stalled", {31'd0, Fault}, 32'd0);
            if (bus_req) begin
               if (n_req == 0) begin
                  chk("bus_addr", bus_addr, v.exp_addr);
                  chk("bus_be", {28'd0, bus_be}, {28'd0, v.exp_be});
                  chk("bus_we", {31'd0, bus_we}, {31'd0, v.exp_we});
                  chk("bus_wdata", bus_wdata, v.exp_wdata);
               end
               bus_ack = (v.mode <= 1) && (n_req == v.delay);
               bus_err = (v.mode == 1 || v.mode == 2) && (n_req == v.delay);
               n_req++;
            end else begin
               bus_ack = 1'b0;
               bus_err = 1'b0;
            end
            @(negedge clk);
         end else begin
            done = 1'b1;
            exp_rd = v.exp_fault ? 32'd0 : (v.rd && !v.wr) ? v.exp_load : rd_model;
            chk("fault_in_done", {31'd0, Fault}, {31'd0, v.exp_fault});
            chk("readdata_in_done", ReadData, exp_rd);
            chk("req_low_in_done", {31'd0, bus_req}, 32'd0);
         end
      end
      if (!done) chk("completion_bound", 32'd0, 32'd1);
      chk("req_cycles", n_req, v.exp_nreq);
      chk("stall_cycles", n_stall, v.exp_nreq + 1);
      if (!v.exp_fault && v.rd && !v.wr) rd_model = v.exp_load;
      MemRead = 1'b0; MemWrite = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
      @(negedge clk);
      chk("idle_stall", {31'd0, Stall}, 32'd0);
      chk("idle_fault", {31'd0, Fault}, 32'd0);
      chk("readdata_hold", ReadData, rd_model);
   endtask

   // Transaction-level expectation from the access rules.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      int nbytes;
      int off;
      bit mis;
      bit late;
      r = v;
      nbytes = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
      off = int'(v.addr % 4);
      mis = (v.addr % nbytes) != 0;
      late = (v.delay >= TMO) || (v.mode == 3);
      r.exp_addr = v.addr - 32'(off);
      r.exp_be = 4'(((1 << nbytes) - 1) << off);
      r.exp_we = v.wr;
      if (!v.wr) r.exp_wdata = 32'd0;
      else if (nbytes == 1) r.exp_wdata = 32'(v.wdata[7:0]) * 32'h01010101;
      else if (nbytes == 2) r.exp_wdata = 32'(v.wdata[15:0]) * 32'h00010001;
      else r.exp_wdata = v.wdata;
      r.exp_load = v.rdata >> (8 * off);
      r.exp_fault = mis || late || (v.mode == 1) || (v.mode == 2);
      r.exp_nreq = mis ? 0 : late ? TMO : v.delay + 1;
      return r;
   endfunction

   initial begin
      vec_t v;
      vt[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF,
                 32'h100, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1};
      vt[1]  = '{1'b0, 1'b1, 3'b000, 32'h203, 32'h123456A5, 0, 1, 32'h0,
                 32'h200, 4'h8, 1'b1, 32'hA5A5A5A5, 32'h0, 1'b0, 2};
      vt[2]  = '{1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 0, 2, 32'h12345678,
                 32'h200, 4'hC, 1'b0, 32'h0, 32'h00001234, 1'b0, 3};
      vt[3]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'hFFFFFFFF,
                 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b1, 0};
      vt[4]  = '{1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 3, 0, 32'h11111111,
                 32'h300, 4'hF, 1'b0, 32'h0, 32'h0, 1'b1, 4};
      vt[5]  = '{1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 1, 1, 32'h22222222,
                 32'h10, 4'h3, 1'b0, 32'h0, 32'h0, 1'b1, 2};
      vt[6]  = '{1'b1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 0, 0, 32'h33333333,
                 32'h40, 4'hF, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0, 1};
      vt[7]  = '{1'b0, 1'b1, 3'b001, 32'h301, 32'hBEEF, 0, 0, 32'h0,
                 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 1'b1, 0};
      vt[8]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 2, 0, 32'h44444444,
                 32'h100, 4'h2, 1'b0, 32'h0, 32'h0, 1'b1, 1};
      vt[9]  = '{1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 0, 3, 32'hAABBCCDD,
                 32'h100, 4'h2, 1'b0, 32'h0, 32'h00AABBCC, 1'b0, 4};
      vt[10] = '{1'b0, 1'b1, 3'b001, 32'h006, 32'hFFFF1234, 0, 0, 32'h0,
                 32'h4, 4'hC, 1'b1, 32'h12341234, 32'h0, 1'b0, 1};

      reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
      ALUResult = 32'h0; WriteData = 32'h0; bus_rdata = 32'h0;
      bus_ack = 1'b0; bus_err = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      chk("rst_readdata", ReadData, 32'd0);
      chk("rst_fault", {31'd0, Fault}, 32'd0);
      chk("rst_stall", {31'd0, Stall}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) run_access(vt[i]);

      // Reset while a request is outstanding.
      MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h500; bus_ack = 1'b0;
      @(negedge clk);
      chk("midreq_req_high", {31'd0, bus_req}, 32'd1);
      reset = 1'b0; MemRead = 1'b0;
      #1;
      chk("midreq_req", {31'd0, bus_req}, 32'd0);
      chk("midreq_stall", {31'd0, Stall}, 32'd0);
      chk("midreq_fault", {31'd0, Fault}, 32'd0);
      chk("midreq_readdata", ReadData, 32'd0);
      chk("midreq_addr", bus_addr, 32'd0);
      chk("midreq_be", {28'd0, bus_be}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      rd_model = 32'd0;
      @(negedge clk);
      run_access(vt[0]);

      // Back-to-back loads: one IDLE cycle between completions.
      MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h80;
      bus_rdata = 32'h5A5A0001; bus_ack = 1'b1;
      #1;
      chk("b2b_c0_stall", {31'd0, Stall}, 32'd1);
      chk("b2b_c0_req", {31'd0, bus_req}, 32'd0);
      @(negedge clk);
      chk("b2b_c1_req", {31'd0, bus_req}, 32'd1);
      @(negedge clk);
      chk("b2b_c2_stall", {31'd0, Stall}, 32'd0);
      chk("b2b_c2_readdata", ReadData, 32'h5A5A0001);
      @(negedge clk);
      chk("b2b_c3_stall", {31'd0, Stall}, 32'd1);
      chk("b2b_c3_req", {31'd0, bus_req}, 32'd0);
      @(negedge clk);
      chk("b2b_c4_req", {31'd0, bus_req}, 32'd1);
      @(negedge clk);
      chk("b2b_c5_stall", {31'd0, Stall}, 32'd0);
      MemRead = 1'b0; bus_ack = 1'b0;
      rd_model = 32'h5A5A0001;
      @(negedge clk);

      // Randomized accesses against the transaction model.
      for (int n = 0; n < 200; n++) begin
         int m;
         v = vt[0];
         m = int'($urandom_range(0, 3));
         v.rd = (m != 1);
         v.wr = (m != 0);
         v.f3 = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
         v.addr = $urandom;
         if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
         v.wdata = $urandom;
         v.rdata = $urandom;
         m = int'($urandom_range(0, 9));
         v.mode = (m < 6) ? 0 : (m - 6);
         v.delay = int'($urandom_range(0, 5));
         run_access(model(v));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
